// File: rtl/ode_arith_pkg.sv
// Shared widths and state encoding for the ODE arithmetic datapath blocks.
//------------------------------------------------------------------------------
// Module   : ode_arith_pkg
// Brief    : Common localparams and FSM state type for ODE arithmetic units
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ode_arith_pkg;

  localparam int DATA_W  = 16;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice: every carry is a flat sum of products.
//------------------------------------------------------------------------------
// Module   : cla_slice
// Brief    : SLICE-bit lookahead adder slice (a + b + cin -> sum, cout)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cla_slice
  import ode_arith_pkg::*;
#(
  parameter int SLICE = SLICE_W
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic             run;
  logic             term;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, same equations as the 4-bit CLA
  always_comb begin
    c    = '0;
    run  = 1'b0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = g[i];
      run  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (run & g[j]);
        run  = run & p[j];
      end
      c[i+1] = term | (run & cin);
    end
  end

  assign sum  = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

`default_nettype wire

// File: rtl/seq_cla_subtractor.sv
// Iterative signed subtractor: a + ~b + 1, one lookahead slice per clock.
//------------------------------------------------------------------------------
// Module   : seq_cla_subtractor
// Brief    : Multi-cycle CLA subtractor with valid/ready on both sides
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_cla_subtractor
  import ode_arith_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             no_borrow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SHW    = $clog2(WIDTH) + 1;

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             no_borrow_q, no_borrow_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;

  assign shamt      = SHW'(idx_q) * SHW'(SLICE);
  assign a_sh       = a_q >> shamt;
  assign nb_sh      = nb_q >> shamt;
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (a_sh[SLICE-1:0]),
    .b    (nb_sh[SLICE-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Accumulator with the current slice merged in; on the last slice this is the answer
  assign acc_next = (acc_q & ~(WIDTH'({SLICE{1'b1}}) << shamt))
                  | (WIDTH'(slice_sum) << shamt);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    no_borrow_d = no_borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          acc_d   = '0;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_next;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          idx_d       = '0;
          state_d     = DONE;
          result_d    = acc_next;
          no_borrow_d = slice_cout;
          // b's sign bit is the inverse of the stored complement
          overflow_d  = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (acc_next[WIDTH-1] ^ a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      no_borrow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      no_borrow_q <= no_borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign no_borrow = no_borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_cla_subtractor.sv
// Directed self-checking bench for seq_cla_subtractor.
//------------------------------------------------------------------------------
// Module   : tb_seq_cla_subtractor
// Brief    : Directed vectors with hand-computed results and timing checks
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_cla_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        no_borrow;

  int n_cmp;
  int n_err;

  seq_cla_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .no_borrow (no_borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair with out_ready high and check latency, flags and one-cycle valid
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic eo, input logic enb);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    tick();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".no_borrow"}, 32'(no_borrow), 32'(enb));
    tick();
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.no_borrow", 32'(no_borrow), 32'd0);

    run_op("basic",     16'd100,   16'd30,    16'h0046, 1'b0, 1'b1);
    run_op("neg_ovf",   16'h8000,  16'h0001,  16'h7FFF, 1'b1, 1'b1);
    run_op("pos_ovf",   16'h7FFF,  16'hFFFF,  16'h8000, 1'b1, 1'b0);
    run_op("ripple",    16'h1000,  16'h0001,  16'h0FFF, 1'b0, 1'b1);
    run_op("zero_m1",   16'h0000,  16'h0001,  16'hFFFF, 1'b0, 1'b0);

    // Backpressure: result held under out_ready=0 while in_valid and operands toggle
    a = 16'h1234; b = 16'h0234; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp.out_valid", 32'(out_valid), 32'd1);
    chk("bp.result", 32'(result), 32'h1000);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'(i * 16'h1111);
      b = 16'(16'hFFFF - i);
      tick();
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_result", 32'(result), 32'h1000);
      chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_in_ready", 32'(in_ready), 32'd1);
    chk("bp.result_kept", 32'(result), 32'h1000);
    tick();
    chk("bp.no_new_op", 32'(in_ready), 32'd1);

    // Reset during the second CALC cycle
    a = 16'h00FF; b = 16'h0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.result", 32'(result), 32'd0);
    chk("mid_rst.overflow", 32'(overflow), 32'd0);
    chk("mid_rst.no_borrow", 32'(no_borrow), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst.no_partial", 32'(out_valid), 32'd0);
    run_op("after_rst", 16'd5, 16'd7, 16'hFFFE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_cla_subtractor.md
Name: seq_cla_subtractor

Overview:
- Multi-cycle signed subtractor for the ODE datapath: computes result = a - b as a + ~b + 1.
- Processes one 4-bit carry-lookahead slice per clock, carrying between slices through a registered carry.
- Complements the combinational CLA adder. Trades latency for area in the iterative solver's step-update path.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle (lookahead slice width).
- NSLICE, WIDTH/SLICE: number of compute cycles; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  signed minuend
- b  input  WIDTH  signed subtrahend
- out_valid  output  1  result/overflow/no_borrow valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  signed difference a - b, modulo 2^WIDTH
- overflow  output  1  signed overflow of a - b
- no_borrow  output  1  final carry out; 1 when a >= b as unsigned

Behaviour:
- Reset (async, on rst_n low):
  - state=IDLE; out_valid=0, result=0, overflow=0, no_borrow=0.
  - Internal accumulator, slice index and carry cleared.
  - in_ready=1 once reset is released.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready at an edge, latch a, latch ~b, set carry=1, idx=0, go to CALC.
  - CALC: in_ready=0. Each cycle, the slice computes a_l[idx] + nb_l[idx] + carry with lookahead (p=a^nb, g=a&nb).
    - acc[idx*SLICE +: SLICE] <= sum; carry <= slice cout; idx <= idx+1.
    - When idx==NSLICE-1, go to DONE. In the same edge, load the outputs: result <= final acc, no_borrow <= final cout, overflow <= (a[MSB]^b[MSB]) & (result[MSB]^a[MSB]).
  - DONE: out_valid=1, outputs held stable. On out_ready high, go to IDLE with out_valid=0 on the next edge.
- Latency and throughput:
  - Operands accepted at edge k; out_valid is high after edge k+NSLICE (k+4 by default).
  - Minimum spacing between accepts is NSLICE+2 cycles (accept, NSLICE compute cycles, result handshake).
- Output stability:
  - result, overflow and no_borrow change only on the CALC->DONE edge or on reset.
  - Between operations they hold the previous value.
- Operand capture:
  - in_valid while not in IDLE is ignored; no queuing.
  - a and b may change freely after acceptance.
- Simultaneous handshakes: out_ready may be high on DONE entry; the handshake completes on the first DONE cycle.
- Reset mid-operation: an in-flight operation is aborted immediately and no partial result is ever presented.
- Arithmetic: two's-complement, wrap modulo 2^WIDTH. overflow and no_borrow follow the formulas above exactly.

Decomposition:
- Shared package ode_arith_pkg:
  - localparams DATA_W=16 and SLICE_W=4.
  - State enum sub_state_t {IDLE, CALC, DONE}.
- Sub-module cla_slice: SLICE-bit combinational lookahead slice (a, b, cin -> sum, cout).
  - Instantiated once.
  - Shares carry equations with the team's existing 4-bit lookahead block.

Test Plan:
- Basic subtraction: a=100, b=30, out_ready=1 -> result=0x0046, overflow=0, no_borrow=1; out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
- Negative overflow: a=0x8000, b=0x0001 -> result=0x7FFF, overflow=1, no_borrow=1.
- Positive overflow: a=0x7FFF, b=0xFFFF -> result=0x8000, overflow=1, no_borrow=0.
- Borrow ripple across all slices: a=0x1000, b=0x0001 -> result=0x0FFF, overflow=0, no_borrow=1. Also a=0x0000, b=0x0001 -> result=0xFFFF, no_borrow=0, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after DONE with in_valid pulsing and a/b changing -> out_valid stays 1, result stable, in_ready=0, no new op taken. Then set out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during the 2nd CALC cycle -> out_valid=0 and result=0 immediately. After release, in_ready=1, and a fresh op 5-7 gives result=0xFFFE, overflow=0, no_borrow=0.
